// File: rtl/ysyx_220053_if_stage_pkg.sv
// Shared IF-stage definitions: FSM state encodings, reset PC default and the
// canonical NOP word.
package ysyx_220053_if_stage_pkg;

    localparam int          XLEN_DEF     = 64;
    localparam logic [63:0] RESET_PC_DEF = 64'h8000_0000;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } if_state_e;

endpackage

// File: rtl/ysyx_220053_if_stage_if.sv
// Fetch-stage signal bundle: EX redirect, instruction bus request/response and
// the {pc, instr} handoff to ID_Reg.
interface ysyx_220053_if_stage_if #(
    parameter int XLEN = 64
) ();
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    logic            req_valid;
    logic [XLEN-1:0] req_addr;
    logic            req_ready;
    logic            resp_valid;
    logic [31:0]     resp_data;

    logic            out_valid;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_instr;
    logic            out_ready;

    modport master (
        input  redirect_valid, redirect_pc, req_ready, resp_valid, resp_data, out_ready,
        output req_valid, req_addr, out_valid, out_pc, out_instr
    );

    modport slave (
        output redirect_valid, redirect_pc, req_ready, resp_valid, resp_data, out_ready,
        input  req_valid, req_addr, out_valid, out_pc, out_instr
    );
endinterface

// File: rtl/ysyx_220053_if_stage.sv
// Instruction-fetch stage: PC register, single-outstanding fetch FSM, stale
// response drop flag and instruction buffer in one flat block.
module ysyx_220053_if_stage
    import ysyx_220053_if_stage_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
    input  logic                   clk,
    input  logic                   rst,
    ysyx_220053_if_stage_if.master bus
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(64'h3);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(64'h4);

    if_state_e       state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] addr_q;
    logic [31:0]     instr_buf;
    logic            drop;
    logic [XLEN-1:0] redirect_tgt;

    assign redirect_tgt = bus.redirect_pc & ALIGN_MASK;

    // addr_q is the bus address; it only reloads on entry to REQ so an
    // unaccepted request never changes address even if pc is redirected.
    // drop marks the in-flight (or about-to-issue) request as stale.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_BOOT;
            pc        <= RESET_PC;
            addr_q    <= RESET_PC;
            drop      <= 1'b0;
            instr_buf <= 32'h0;
        end else begin
            case (state)
                ST_BOOT: begin
                    state <= ST_REQ;
                    if (bus.redirect_valid) begin
                        pc     <= redirect_tgt;
                        addr_q <= redirect_tgt;
                    end else begin
                        addr_q <= pc;
                    end
                end
                ST_REQ: begin
                    if (bus.redirect_valid) begin
                        pc   <= redirect_tgt;
                        drop <= 1'b1;
                    end
                    if (bus.req_ready) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.resp_valid) begin
                        if (bus.redirect_valid) begin
                            pc     <= redirect_tgt;
                            addr_q <= redirect_tgt;
                            drop   <= 1'b0;
                            state  <= ST_REQ;
                        end else if (drop) begin
                            addr_q <= pc;
                            drop   <= 1'b0;
                            state  <= ST_REQ;
                        end else begin
                            instr_buf <= bus.resp_data;
                            state     <= ST_HOLD;
                        end
                    end else if (bus.redirect_valid) begin
                        pc   <= redirect_tgt;
                        drop <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (bus.redirect_valid) begin
                        pc     <= redirect_tgt;
                        addr_q <= redirect_tgt;
                        state  <= ST_REQ;
                    end else if (bus.out_ready) begin
                        pc     <= pc + PC_STEP;
                        addr_q <= pc + PC_STEP;
                        state  <= ST_REQ;
                    end
                end
                default: state <= ST_BOOT;
            endcase
        end
    end

    assign bus.req_valid = (state == ST_REQ);
    assign bus.req_addr  = addr_q;
    // A redirect kills the held instruction in the same cycle.
    assign bus.out_valid = (state == ST_HOLD) && !bus.redirect_valid;
    assign bus.out_pc    = pc;
    assign bus.out_instr = instr_buf;

endmodule

// File: tb/tb_ysyx_220053_if_stage.sv
// Directed bench for the IF stage: normal fetch, ID stall, redirects in each
// state and reset during an outstanding fetch.
module tb_ysyx_220053_if_stage;
    import ysyx_220053_if_stage_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total    = 0;
    int   pass_cnt = 0;
    int   fail_cnt = 0;

    ysyx_220053_if_stage_if #(.XLEN(64)) ifc ();

    ysyx_220053_if_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        ifc.redirect_valid = 1'b0;
        ifc.redirect_pc    = '0;
        ifc.req_ready      = 1'b0;
        ifc.resp_valid     = 1'b0;
        ifc.resp_data      = '0;
        ifc.out_ready      = 1'b0;

        // reset values
        next();
        next();
        chk("rst_req_valid", 64'(ifc.req_valid), 64'd0);
        chk("rst_out_valid", 64'(ifc.out_valid), 64'd0);
        chk("rst_req_addr", ifc.req_addr, 64'h8000_0000);
        chk("rst_out_pc", ifc.out_pc, 64'h8000_0000);
        chk("rst_out_instr", 64'(ifc.out_instr), 64'd0);

        // 1: basic fetch stream
        rst = 1'b0;
        ifc.req_ready = 1'b1;
        ifc.out_ready = 1'b1;
        #1;
        chk("t1_boot_req_valid", 64'(ifc.req_valid), 64'd0);
        next();
        chk("t1_req_valid", 64'(ifc.req_valid), 64'd1);
        chk("t1_req_addr0", ifc.req_addr, 64'h8000_0000);
        next();
        chk("t1_wait_req_valid", 64'(ifc.req_valid), 64'd0);
        ifc.resp_valid = 1'b1;
        ifc.resp_data  = NOP_INSTR;
        next();
        ifc.resp_valid = 1'b0;
        chk("t1_out_valid", 64'(ifc.out_valid), 64'd1);
        chk("t1_out_pc", ifc.out_pc, 64'h8000_0000);
        chk("t1_out_instr", 64'(ifc.out_instr), 64'h13);
        next();
        chk("t1_out_valid_drop", 64'(ifc.out_valid), 64'd0);
        chk("t1_req_addr1", ifc.req_addr, 64'h8000_0004);
        next();
        ifc.resp_valid = 1'b1;
        ifc.resp_data  = 32'h0010_0093;
        next();
        ifc.resp_valid = 1'b0;

        // 2: ID stall for 5 cycles in HOLD
        ifc.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_out_valid", 64'(ifc.out_valid), 64'd1);
            chk("t2_hold_out_pc", ifc.out_pc, 64'h8000_0004);
            chk("t2_hold_out_instr", 64'(ifc.out_instr), 64'h0010_0093);
            chk("t2_hold_req_valid", 64'(ifc.req_valid), 64'd0);
            next();
        end
        ifc.out_ready = 1'b1;
        chk("t2_release_out_valid", 64'(ifc.out_valid), 64'd1);
        next();
        chk("t2_next_req_valid", 64'(ifc.req_valid), 64'd1);
        chk("t2_next_req_addr", ifc.req_addr, 64'h8000_0008);
        next();

        // 3: redirect in WAIT, late response is discarded
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc    = 64'h8000_0100;
        next();
        ifc.redirect_valid = 1'b0;
        chk("t3_wait_req_valid", 64'(ifc.req_valid), 64'd0);
        chk("t3_wait_out_valid", 64'(ifc.out_valid), 64'd0);
        next();
        ifc.resp_valid = 1'b1;
        ifc.resp_data  = 32'hDEAD_BEEF;
        next();
        ifc.resp_valid = 1'b0;
        chk("t3_out_valid", 64'(ifc.out_valid), 64'd0);
        chk("t3_req_valid", 64'(ifc.req_valid), 64'd1);
        chk("t3_req_addr", ifc.req_addr, 64'h8000_0100);
        chk("t3_instr_kept", 64'(ifc.out_instr), 64'h0010_0093);
        next();
        ifc.resp_valid = 1'b1;
        ifc.resp_data  = 32'h0020_0113;
        next();
        ifc.resp_valid = 1'b0;
        chk("t3_hold_out_pc", ifc.out_pc, 64'h8000_0100);
        chk("t3_hold_out_instr", 64'(ifc.out_instr), 64'h0020_0113);

        // 4: redirect in HOLD with out_ready=1 blocks the transfer
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc    = 64'h8000_0040;
        #1;
        chk("t4_out_valid_gated", 64'(ifc.out_valid), 64'd0);
        next();
        ifc.redirect_valid = 1'b0;
        chk("t4_req_valid", 64'(ifc.req_valid), 64'd1);
        chk("t4_req_addr", ifc.req_addr, 64'h8000_0040);
        chk("t4_pc", ifc.out_pc, 64'h8000_0040);

        // 5: unaligned redirect in REQ while bus stalls
        ifc.req_ready      = 1'b0;
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc    = 64'h8000_0203;
        next();
        ifc.redirect_valid = 1'b0;
        chk("t5_req_valid", 64'(ifc.req_valid), 64'd1);
        chk("t5_req_addr_stable", ifc.req_addr, 64'h8000_0040);
        chk("t5_pc_aligned", ifc.out_pc, 64'h8000_0200);
        next();
        chk("t5_req_addr_stable2", ifc.req_addr, 64'h8000_0040);
        ifc.req_ready = 1'b1;
        next();
        ifc.resp_valid = 1'b1;
        ifc.resp_data  = 32'h1111_1111;
        next();
        ifc.resp_valid = 1'b0;
        chk("t5_refetch_valid", 64'(ifc.req_valid), 64'd1);
        chk("t5_refetch_addr", ifc.req_addr, 64'h8000_0200);
        chk("t5_no_out", 64'(ifc.out_valid), 64'd0);
        next();
        ifc.resp_valid = 1'b1;
        ifc.resp_data  = 32'h0030_0193;
        next();
        ifc.resp_valid = 1'b0;
        chk("t5_out_pc", ifc.out_pc, 64'h8000_0200);
        chk("t5_out_instr", 64'(ifc.out_instr), 64'h0030_0193);
        next();
        chk("t5_next_addr", ifc.req_addr, 64'h8000_0204);
        next();

        // 6: reset while a fetch is outstanding
        rst = 1'b1;
        #1;
        chk("t6_rst_req_valid", 64'(ifc.req_valid), 64'd0);
        chk("t6_rst_req_addr", ifc.req_addr, 64'h8000_0000);
        chk("t6_rst_out_pc", ifc.out_pc, 64'h8000_0000);
        chk("t6_rst_out_instr", 64'(ifc.out_instr), 64'd0);
        next();
        rst = 1'b0;
        ifc.resp_valid = 1'b1;
        ifc.resp_data  = 32'h0000_0BAD;
        #1;
        chk("t6_boot_req_valid", 64'(ifc.req_valid), 64'd0);
        next();
        ifc.resp_valid = 1'b0;
        chk("t6_req_valid", 64'(ifc.req_valid), 64'd1);
        chk("t6_req_addr", ifc.req_addr, 64'h8000_0000);
        chk("t6_out_valid", 64'(ifc.out_valid), 64'd0);
        chk("t6_out_instr", 64'(ifc.out_instr), 64'd0);
        next();
        ifc.resp_valid = 1'b1;
        ifc.resp_data  = NOP_INSTR;
        next();
        ifc.resp_valid = 1'b0;
        chk("t6_out_valid_final", 64'(ifc.out_valid), 64'd1);
        chk("t6_out_pc_final", ifc.out_pc, 64'h8000_0000);
        chk("t6_out_instr_final", 64'(ifc.out_instr), 64'h13);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
